// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared constants for the fetch and decode stages: instruction width,
//   bubble encoding (addi x0,x0,0), default reset PC and the PC step.
//   Also holds a small helper that classifies a redirect target as
//   word-misaligned.
package fetch_stage_pkg;

    localparam int          INST_SIZE        = 32;
    localparam logic [31:0] NOP_ENCODING     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // A redirect target is misaligned when either of its two low bits is set.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// pc_register
//   Program-counter state for the fetch stage, including the next-PC mux.
//   Update priority on each rising edge: rst > redirect > hold > +4.
//
// Ports
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset, loads RESET_PC
//   enable      : 1 = advance sequentially, 0 = hold (ignored on redirect)
//   redirect    : load the redirect target this edge
//   target_word : redirect target bits [31:2]; the low bits are forced to 0
//   pc          : current fetch PC
module pc_register
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        redirect,
    input  logic [29:0] target_word,
    output logic [31:0] pc
);

    logic [31:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = {target_word, 2'b00};
        end else if (enable) begin
            // Natural 32-bit wrap: FFFF_FFFC + 4 -> 0.
            pc_next = pc + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage: PC register (pc_register sub-module), IF/ID
//   pipeline register, sticky misaligned-redirect flag and a count of
//   instructions accepted into IF/ID. Instruction memory is read
//   combinationally, so an instruction reaches InstrD one edge after its
//   address is presented.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   STALL_F      : hold the fetch PC
//   STALL_D      : hold the IF/ID register
//   FLUSH_D      : replace IF/ID with a bubble
//   PC_SRC       : redirect request from execute
//   PC_TARGET    : redirect address
//   IMEM_ADDR    : instruction memory address (= fetch PC)
//   IMEM_RDATA   : instruction word at IMEM_ADDR
//   InstrD       : decode-stage instruction
//   PCD          : PC of InstrD
//   PC_PLUS4D    : PCD + 4
//   VALID_D      : InstrD is a fetched instruction, not a bubble
//   MISALIGN_ERR : sticky, set by a redirect to a non-word-aligned target
//   FETCH_CNT    : number of loads into IF/ID
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0]          RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INST_SIZE-1:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 STALL_F,
    input  logic                 STALL_D,
    input  logic                 FLUSH_D,
    input  logic                 PC_SRC,
    input  logic [31:0]          PC_TARGET,
    output logic [31:0]          IMEM_ADDR,
    input  logic [INST_SIZE-1:0] IMEM_RDATA,
    output logic [INST_SIZE-1:0] InstrD,
    output logic [31:0]          PCD,
    output logic [31:0]          PC_PLUS4D,
    output logic                 VALID_D,
    output logic                 MISALIGN_ERR,
    output logic [31:0]          FETCH_CNT
);

    logic [31:0]          pc_p0;
    logic [INST_SIZE-1:0] instr_p1;
    logic [31:0]          pc_p1;
    logic [31:0]          pc_plus4_p1;
    logic                 vld_p1;
    logic                 misalign;
    logic [31:0]          fetch_cnt;
    logic                 load;

    // Stage 0: fetch PC
    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk         (clk),
        .rst         (rst),
        .enable      (!STALL_F),
        .redirect    (PC_SRC),
        .target_word (PC_TARGET[31:2]),
        .pc          (pc_p0)
    );

    assign IMEM_ADDR = pc_p0;

    // IF/ID loads only when neither flushed nor stalled; a reload of the
    // same address while STALL_F holds the PC is a real, counted load.
    assign load = !FLUSH_D && !STALL_D;

    // Stage 1: IF/ID register
    always_ff @(posedge clk) begin
        if (rst || FLUSH_D) begin
            instr_p1    <= NOP_INSTR;
            pc_p1       <= 32'd0;
            pc_plus4_p1 <= PC_STEP;
            vld_p1      <= 1'b0;
        end else if (load) begin
            instr_p1    <= IMEM_RDATA;
            pc_p1       <= pc_p0;
            pc_plus4_p1 <= pc_p0 + PC_STEP;
            vld_p1      <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'd0;
            misalign  <= 1'b0;
        end else begin
            if (load) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (PC_SRC && is_misaligned(PC_TARGET[1:0])) begin
                misalign <= 1'b1;
            end
        end
    end

    assign InstrD       = instr_p1;
    assign PCD          = pc_p1;
    assign PC_PLUS4D    = pc_plus4_p1;
    assign VALID_D      = vld_p1;
    assign MISALIGN_ERR = misalign;
    assign FETCH_CNT    = fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, stall_d, flush_d, pc_src;
    logic [31:0] pc_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr_d, pc_d, pc_plus4_d, fetch_cnt;
    logic        valid_d, misalign_err;

    // Second instance exercises the PC wrap with a high reset PC.
    logic        z_stall_f = 1'b0, z_stall_d = 1'b0, z_flush_d = 1'b0, z_pc_src = 1'b0;
    logic [31:0] z_target = 32'd0;
    logic [31:0] w_addr, w_rdata, w_instr, w_pcd, w_pc4, w_cnt;
    logic        w_valid, w_mis;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
    assign w_rdata    = w_addr ^ 32'hA5A5_0000;

    fetch_stage dut (
        .clk(clk), .rst(rst), .STALL_F(stall_f), .STALL_D(stall_d),
        .FLUSH_D(flush_d), .PC_SRC(pc_src), .PC_TARGET(pc_target),
        .IMEM_ADDR(imem_addr), .IMEM_RDATA(imem_rdata), .InstrD(instr_d),
        .PCD(pc_d), .PC_PLUS4D(pc_plus4_d), .VALID_D(valid_d),
        .MISALIGN_ERR(misalign_err), .FETCH_CNT(fetch_cnt)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .STALL_F(z_stall_f), .STALL_D(z_stall_d),
        .FLUSH_D(z_flush_d), .PC_SRC(z_pc_src), .PC_TARGET(z_target),
        .IMEM_ADDR(w_addr), .IMEM_RDATA(w_rdata), .InstrD(w_instr),
        .PCD(w_pcd), .PC_PLUS4D(w_pc4), .VALID_D(w_valid),
        .MISALIGN_ERR(w_mis), .FETCH_CNT(w_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"},  imem_addr,    32'h0);
        chk({tag, "_instr"}, instr_d,      32'h13);
        chk({tag, "_pcd"},   pc_d,         32'h0);
        chk({tag, "_pc4"},   pc_plus4_d,   32'h4);
        chk({tag, "_vld"},   {31'd0, valid_d},      32'h0);
        chk({tag, "_mis"},   {31'd0, misalign_err}, 32'h0);
        chk({tag, "_cnt"},   fetch_cnt,    32'h0);
    endtask

    initial begin
        rst = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src = 0; pc_target = 0;
        step();
        chk_reset("rst0");
        chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
        rst = 1'b0;

        // Free-running fetch
        step();
        chk("run1_addr",  imem_addr, 32'h4);
        chk("run1_instr", instr_d,   32'hA5A5_0000);
        chk("run1_vld",   {31'd0, valid_d}, 32'h1);
        chk("wrap1_addr", w_addr,    32'hFFFF_FFFC);
        step();
        chk("run2_addr",  imem_addr, 32'h8);
        chk("run2_instr", instr_d,   32'hA5A5_0004);
        chk("wrap2_addr", w_addr,    32'h0);
        chk("wrap2_pcd",  w_pcd,     32'hFFFF_FFFC);
        chk("wrap2_pc4",  w_pc4,     32'h0);
        step();
        chk("run3_addr",  imem_addr, 32'hC);
        chk("run3_instr", instr_d,   32'hA5A5_0008);
        chk("run3_pcd",   pc_d,      32'h8);
        chk("run3_pc4",   pc_plus4_d, 32'hC);
        chk("run3_cnt",   fetch_cnt, 32'd3);

        // Full stall at PC_F=8
        rst = 1'b1; step(); rst = 1'b0;
        step(); step();
        chk("pre_stall_addr", imem_addr, 32'h8);
        stall_f = 1; stall_d = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_addr",  imem_addr, 32'h8);
            chk("stall_instr", instr_d,   32'hA5A5_0004);
            chk("stall_pcd",   pc_d,      32'h4);
            chk("stall_cnt",   fetch_cnt, 32'd2);
        end
        stall_f = 0; stall_d = 0;
        step();
        chk("resume_addr",  imem_addr, 32'hC);
        chk("resume_instr", instr_d,   32'hA5A5_0008);
        chk("resume_cnt",   fetch_cnt, 32'd3);

        // PC stall only: same instruction reloaded and counted
        stall_f = 1;
        step();
        chk("refetch1_addr",  imem_addr, 32'hC);
        chk("refetch1_instr", instr_d,   32'hA5A5_000C);
        chk("refetch1_cnt",   fetch_cnt, 32'd4);
        step();
        chk("refetch2_pcd",   pc_d,      32'hC);
        chk("refetch2_cnt",   fetch_cnt, 32'd5);

        // Reset in the middle of a full stall
        stall_d = 1;
        step();
        chk("hold5_cnt", fetch_cnt, 32'd5);
        rst = 1'b1;
        step();
        chk_reset("rst_stall");
        rst = 1'b0; stall_f = 0; stall_d = 0;
        step();
        chk("post_rst_addr",  imem_addr, 32'h4);
        chk("post_rst_instr", instr_d,   32'hA5A5_0000);
        chk("post_rst_pcd",   pc_d,      32'h0);

        // Redirect with flush while PC stalled
        pc_src = 1; pc_target = 32'h100; flush_d = 1; stall_f = 1;
        step();
        chk("redir_addr",  imem_addr, 32'h100);
        chk("redir_instr", instr_d,   32'h13);
        chk("redir_vld",   {31'd0, valid_d}, 32'h0);
        chk("redir_pcd",   pc_d,      32'h0);
        chk("redir_cnt",   fetch_cnt, 32'd1);
        pc_src = 0; flush_d = 0; stall_f = 0;
        step();
        chk("tgt_instr", instr_d,  32'hA5A5_0100);
        chk("tgt_pcd",   pc_d,     32'h100);
        chk("tgt_vld",   {31'd0, valid_d}, 32'h1);
        chk("tgt_mis",   {31'd0, misalign_err}, 32'h0);

        // Misaligned redirect without flush
        pc_src = 1; pc_target = 32'h102;
        step();
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_flag", {31'd0, misalign_err}, 32'h1);
        chk("mis_instr", instr_d, 32'hA5A5_0104);
        pc_src = 0; pc_target = 32'h0;
        step(); step();
        chk("mis_sticky_addr", imem_addr, 32'h108);
        chk("mis_sticky", {31'd0, misalign_err}, 32'h1);
        rst = 1'b1;
        step();
        chk("mis_clr", {31'd0, misalign_err}, 32'h0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset.
REQ-002 The block SHALL take parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-003 The block SHALL take parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), which is the bubble encoding.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port STALL_F, input, 1: hold PC_F.
REQ-007 Port STALL_D, input, 1: hold the IF/ID register.
REQ-008 Port FLUSH_D, input, 1: replace the IF/ID contents with a bubble.
REQ-009 Port PC_SRC, input, 1: redirect request from execute (taken branch or jump).
REQ-010 Port PC_TARGET, input, 32: redirect address.
REQ-011 Port IMEM_ADDR, output, 32: instruction-memory address, equal to PC_F.
REQ-012 Port IMEM_RDATA, input, `INST_SIZE: instruction word; combinational read, same cycle as IMEM_ADDR.
REQ-013 Port InstrD, output, `INST_SIZE: decode-stage instruction, feeding the decode control unit.
REQ-014 Port PCD, output, 32: PC of InstrD.
REQ-015 Port PC_PLUS4D, output, 32: PCD + 4.
REQ-016 Port VALID_D, output, 1: InstrD is a real fetched instruction, not a bubble.
REQ-017 Port MISALIGN_ERR, output, 1: sticky flag, set when a redirect target is misaligned.
REQ-018 Port FETCH_CNT, output, 32: count of instructions accepted into IF/ID.

Function
REQ-019 PC_F SHALL update every clock edge by this priority: rst > PC_SRC > STALL_F > sequential.
- rst: PC_F <= RESET_PC.
- PC_SRC: PC_F <= {PC_TARGET[31:2],2'b00}.
- STALL_F: PC_F holds.
- Otherwise: PC_F <= PC_F + 4, mod 2^32, wrapping 32'hFFFF_FFFC -> 0.
REQ-020 IMEM_ADDR SHALL equal PC_F combinationally.
REQ-021 The IF/ID register SHALL update by this priority: rst > FLUSH_D > STALL_D > load.
- rst or FLUSH_D: InstrD <= NOP_INSTR, PCD <= 0, PC_PLUS4D <= 4, VALID_D <= 0.
- STALL_D: all IF/ID fields hold.
- Load: InstrD <= IMEM_RDATA, PCD <= PC_F, PC_PLUS4D <= PC_F+4, VALID_D <= 1.
REQ-022 Fetch latency SHALL be 1 cycle: the word at PC_F appears on InstrD one edge after it is presented on IMEM_ADDR.
REQ-023 PC_SRC SHALL NOT flush IF/ID by itself; the hazard logic asserts FLUSH_D alongside PC_SRC.
REQ-024 When PC_SRC=1 and PC_TARGET[1:0]!=0, MISALIGN_ERR SHALL set on that edge and stay set until rst.
REQ-025 FETCH_CNT SHALL increment by 1, wrapping at 2^32, on every edge where the IF/ID register takes the load branch; it SHALL NOT change on flush, stall or reset-hold.
REQ-026 STALL_F=1 with STALL_D=0 SHALL load the same instruction again; this case is legal and is counted.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL set PC_F=RESET_PC, InstrD=NOP_INSTR, PCD=0, PC_PLUS4D=4, VALID_D=0, MISALIGN_ERR=0 and FETCH_CNT=0.
REQ-028 rst SHALL override stall, flush and redirect in the same cycle.
REQ-029 Reset asserted in the middle of a stall SHALL clear all state; the first sequential fetch SHALL come from RESET_PC on the first edge after rst deasserts.

Structure
REQ-030 `INST_SIZE, the NOP encoding and the default RESET_PC SHALL live in the shared defines header used by the decode stage.
REQ-031 PC state SHALL live in sub-module pc_register, which holds clk, rst, enable and next-PC mux; the IF/ID register and counter stay in fetch_stage.
REQ-032 The RTL target SHALL be 120-250 lines in total.

Verification
REQ-033 Reset then 3 free-running cycles, with imem returning addr^32'hA5A5_0000: IMEM_ADDR SHALL go 0,4,8,C; InstrD SHALL lag by one cycle; FETCH_CNT SHALL read 3 when PC_F=C.
REQ-034 Assert STALL_F=STALL_D=1 for 2 cycles at PC_F=8: IMEM_ADDR SHALL stay 8 and InstrD/PCD SHALL hold 4's word; FETCH_CNT SHALL be frozen; sequential fetch SHALL resume at C.
REQ-035 Assert PC_SRC=1, PC_TARGET=0x100, FLUSH_D=1 together with STALL_F=1: next cycle IMEM_ADDR SHALL be 0x100, InstrD=0x13 and VALID_D=0; the following cycle InstrD SHALL be word(0x100) and PCD=0x100.
REQ-036 Redirect with PC_TARGET=0x102: PC_F SHALL become 0x100 and MISALIGN_ERR SHALL be 1 and remain 1 until rst.
REQ-037 Use RESET_PC=32'hFFFF_FFF8: after 2 cycles IMEM_ADDR SHALL equal 0 (wrap); PC_PLUS4D for PCD=FFFF_FFFC SHALL equal 0.
REQ-038 Assert rst for one cycle during a stall with FETCH_CNT=5: all outputs SHALL equal the REQ-027 values; FETCH_CNT=0.
